// File: rtl/vp_cfg_ctrl_if.sv
// Signal bundle between software-facing config/frame-sync sources and vp_cfg_ctrl.
// master drives config words and vs; slave (the controller) drives active parameters and status.
interface vp_cfg_ctrl_if #(
  parameter int IX = 11,
  parameter int IY = 11,
  parameter int OX = 11,
  parameter int OY = 11
);
  // cfg_wr is a single-cycle strobe with no ready: the VP_* words are sampled only in
  // the cycle cfg_wr is high, and the controller accepts (or rejects via cfg_err) every write.
  logic          cfg_wr;
  logic [31:0]   VP_CR;
  logic [31:0]   VP_START;
  logic [31:0]   VP_END;
  logic [31:0]   VP_SCALER;
  logic          vs;

  logic          cutter_en;
  logic [1:0]    filter_mode;
  logic          scaler_en;
  logic          color_en;
  logic          edge_en;
  logic          binarizer_en;
  logic          filler_en;
  logic [IX-1:0] start_x;
  logic [IY-1:0] start_y;
  logic [OX-1:0] end_x;
  logic [OY-1:0] end_y;
  logic [IX-1:0] input_x_res;
  logic [IY-1:0] input_y_res;
  logic [OX-1:0] output_x_res;
  logic [OY-1:0] output_y_res;
  logic          cfg_busy;
  logic          cfg_err;
  logic          upd_done;
  logic [15:0]   frame_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output cfg_wr, VP_CR, VP_START, VP_END, VP_SCALER, vs,
    input  cutter_en, filter_mode, scaler_en, color_en, edge_en, binarizer_en, filler_en,
    input  start_x, start_y, end_x, end_y, input_x_res, input_y_res,
    input  output_x_res, output_y_res, cfg_busy, cfg_err, upd_done, frame_cnt, dbg_state
  );

  modport slave (
    input  cfg_wr, VP_CR, VP_START, VP_END, VP_SCALER, vs,
    output cutter_en, filter_mode, scaler_en, color_en, edge_en, binarizer_en, filler_en,
    output start_x, start_y, end_x, end_y, input_x_res, input_y_res,
    output output_x_res, output_y_res, cfg_busy, cfg_err, upd_done, frame_cnt, dbg_state
  );
endinterface

// File: rtl/vp_cfg_ctrl.sv
// Frame-synchronous config controller: validates and stages VP_* writes, then commits
// them to the active parameter set one cycle after the next vs rising edge.
module vp_cfg_ctrl #(
  parameter int H_DISP             = 1280,
  parameter int V_DISP             = 720,
  parameter int INPUT_X_RES_WIDTH  = 11,
  parameter int INPUT_Y_RES_WIDTH  = 11,
  parameter int OUTPUT_X_RES_WIDTH = 11,
  parameter int OUTPUT_Y_RES_WIDTH = 11
) (
  input  logic        clk_vp,
  input  logic        rst_n,
  vp_cfg_ctrl_if.slave bus
);
  localparam int IX = INPUT_X_RES_WIDTH;
  localparam int IY = INPUT_Y_RES_WIDTH;
  localparam int OX = OUTPUT_X_RES_WIDTH;
  localparam int OY = OUTPUT_Y_RES_WIDTH;
  localparam int XW = (IX > OX) ? IX : OX;
  localparam int YW = (IY > OY) ? IY : OY;

  localparam logic [OX-1:0] H_END    = OX'(H_DISP);
  localparam logic [OY-1:0] V_END    = OY'(V_DISP);
  localparam logic [OX-1:0] H_RES_M1 = OX'(H_DISP - 1);
  localparam logic [OY-1:0] V_RES_M1 = OY'(V_DISP - 1);
  localparam logic [7:0]    CR_RST   = 8'h8B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_vs_d;
  logic [15:0]   r_frame_cnt;
  logic          r_cfg_err;
  logic          r_upd_done;

  logic [7:0]    r_stg_cr,    r_cr;
  logic [IX-1:0] r_stg_start_x, r_start_x, r_in_x;
  logic [IY-1:0] r_stg_start_y, r_start_y, r_in_y;
  logic [OX-1:0] r_stg_end_x, r_end_x, r_stg_out_x, r_out_x;
  logic [OY-1:0] r_stg_end_y, r_end_y, r_stg_out_y, r_out_y;

  logic [IX-1:0] w_start_x;
  logic [IY-1:0] w_start_y;
  logic [OX-1:0] w_end_x, w_out_x;
  logic [OY-1:0] w_end_y, w_out_y;
  logic [IX-1:0] w_in_x;
  logic [IY-1:0] w_in_y;
  logic          w_valid;
  logic          w_vs_rise;
  logic          w_unused;

  assign w_start_x = bus.VP_START[IX-1:0];
  assign w_start_y = bus.VP_START[16 +: IY];
  assign w_end_x   = bus.VP_END[OX-1:0];
  assign w_end_y   = bus.VP_END[16 +: OY];
  assign w_out_x   = bus.VP_SCALER[OX-1:0];
  assign w_out_y   = bus.VP_SCALER[16 +: OY];

  assign w_valid = (XW'(w_end_x) > XW'(w_start_x)) && (YW'(w_end_y) > YW'(w_start_y)) &&
                   (w_end_x <= H_END) && (w_end_y <= V_END) &&
                   (w_out_x <= H_RES_M1) && (w_out_y <= V_RES_M1);

  assign w_vs_rise = bus.vs & ~r_vs_d;

  // Crop size is derived from the staged window; wraps at field width like the fields themselves.
  assign w_in_x = IX'(r_stg_end_x) - r_stg_start_x - IX'(1);
  assign w_in_y = IY'(r_stg_end_y) - r_stg_start_y - IY'(1);

  assign w_unused = &{1'b0, bus.VP_CR[31:8],
                      bus.VP_START[31:16+IY], bus.VP_START[15:IX],
                      bus.VP_END[31:16+OY], bus.VP_END[15:OX],
                      bus.VP_SCALER[31:16+OY], bus.VP_SCALER[15:OX]};

  always_ff @(posedge clk_vp) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vs_d        <= 1'b1;
      r_frame_cnt   <= '0;
      r_cfg_err     <= 1'b0;
      r_upd_done    <= 1'b0;
      r_stg_cr      <= CR_RST;
      r_stg_start_x <= '0;
      r_stg_start_y <= '0;
      r_stg_end_x   <= H_END;
      r_stg_end_y   <= V_END;
      r_stg_out_x   <= H_RES_M1;
      r_stg_out_y   <= V_RES_M1;
      r_cr          <= CR_RST;
      r_start_x     <= '0;
      r_start_y     <= '0;
      r_end_x       <= H_END;
      r_end_y       <= V_END;
      r_in_x        <= IX'(H_DISP - 1);
      r_in_y        <= IY'(V_DISP - 1);
      r_out_x       <= H_RES_M1;
      r_out_y       <= V_RES_M1;
    end else begin
      r_vs_d     <= bus.vs;
      r_upd_done <= 1'b0;
      if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (bus.cfg_wr) r_cfg_err <= ~w_valid;
      // Every valid write lands in staging regardless of state; last write wins.
      if (bus.cfg_wr && w_valid) begin
        r_stg_cr      <= bus.VP_CR[7:0];
        r_stg_start_x <= w_start_x;
        r_stg_start_y <= w_start_y;
        r_stg_end_x   <= w_end_x;
        r_stg_end_y   <= w_end_y;
        r_stg_out_x   <= w_out_x;
        r_stg_out_y   <= w_out_y;
      end
      case (r_state)
        S_PEND: begin
          if (bus.cfg_wr)  r_state <= w_valid ? S_PEND : S_IDLE;
          else if (w_vs_rise) r_state <= S_APPLY;
        end
        default: begin
          // APPLY commits the old staging; a same-cycle write is then treated as from IDLE.
          if (r_state == S_APPLY) begin
            r_cr       <= r_stg_cr;
            r_start_x  <= r_stg_start_x;
            r_start_y  <= r_stg_start_y;
            r_end_x    <= r_stg_end_x;
            r_end_y    <= r_stg_end_y;
            r_in_x     <= w_in_x;
            r_in_y     <= w_in_y;
            r_out_x    <= r_stg_out_x;
            r_out_y    <= r_stg_out_y;
            r_upd_done <= 1'b1;
          end
          r_state <= (bus.cfg_wr && w_valid) ? S_PEND : S_IDLE;
        end
      endcase
    end
  end

  assign bus.cutter_en    = r_cr[0];
  assign bus.filter_mode  = r_cr[2:1];
  assign bus.scaler_en    = r_cr[3];
  assign bus.color_en     = r_cr[4];
  assign bus.edge_en      = r_cr[5];
  assign bus.binarizer_en = r_cr[6];
  assign bus.filler_en    = r_cr[7];
  assign bus.start_x      = r_start_x;
  assign bus.start_y      = r_start_y;
  assign bus.end_x        = r_end_x;
  assign bus.end_y        = r_end_y;
  assign bus.input_x_res  = r_in_x;
  assign bus.input_y_res  = r_in_y;
  assign bus.output_x_res = r_out_x;
  assign bus.output_y_res = r_out_y;
  assign bus.cfg_busy     = (r_state == S_PEND);
  assign bus.cfg_err      = r_cfg_err;
  assign bus.upd_done     = r_upd_done;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.dbg_state    = r_state;
endmodule
